instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameters SHALL be:
- word_size, default 10, instruction width.
- address_size, default 8, program-address width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- run  in  1  fetch enable; sampled in IDLE and at instruction hand-off.
- mem_addr  out  address_size  program-memory read address.
- mem_rd  out  1  program-memory read request.
- mem_ack  in  1  memory has placed the addressed word on mem_data this cycle.
- mem_data  in  word_size  program-memory read data.
- ir_data  out  word_size  instruction offered to the instruction register.
- ir_load  out  1  ir_data valid; the instruction register loads when ir_load=1.
- ir_ready  in  1  consumer accepts ir_data this cycle.
- branch_taken  in  1  one-cycle redirect request.
- branch_addr  in  address_size  redirect target.
- pc  out  address_size  address of the instruction being fetched or offered.
- busy  out  1  high in any state other than IDLE.

Function
REQ-003 The FSM SHALL have four states: IDLE, FETCH, FLUSH and DELIVER; all outputs SHALL be registered or decoded from state only (Moore).
REQ-004 Output decode SHALL be:
- mem_rd=1 only in FETCH.
- ir_load=1 only in DELIVER.
- mem_addr=pc at all times.
- busy=1 in every state except IDLE.
REQ-005 IDLE SHALL move to FETCH when run=1 and stay in IDLE otherwise.
REQ-006 In FETCH with mem_ack=1 and branch_taken=0, the block SHALL capture mem_data into ir_data and enter DELIVER on the next edge.
REQ-007 In FETCH with mem_ack=0 and branch_taken=0, the block SHALL remain in FETCH with pc unchanged; there is no timeout.
REQ-008 Transfer SHALL occur on any edge where the state is DELIVER and ir_ready=1.
REQ-009 Without a branch, a transfer SHALL set pc<=pc+1 modulo 2^address_size, so the maximum address wraps to 0.
REQ-010 After a transfer the next state SHALL be FETCH if run=1 and IDLE if run=0.
REQ-011 In DELIVER with ir_ready=0, the block SHALL hold state, ir_data and pc unchanged, with ir_load kept at 1.
REQ-012 branch_taken=1 in FETCH SHALL set pc<=branch_addr and enter FLUSH; any mem_ack in that same cycle SHALL be discarded and ir_data left unchanged.
REQ-013 FLUSH SHALL last exactly one cycle with mem_rd=0, ignore mem_ack, and then enter FETCH; branch_taken in FLUSH SHALL overwrite pc with branch_addr and still go to FETCH.
REQ-014 branch_taken=1 in DELIVER with ir_ready=1 SHALL complete the transfer and load pc<=branch_addr instead of pc+1; the next state follows REQ-010.
REQ-015 branch_taken=1 in DELIVER with ir_ready=0 SHALL set pc<=branch_addr and enter FETCH, dropping the pending instruction (ir_load falls next cycle).
REQ-016 branch_taken=1 in IDLE SHALL set pc<=branch_addr; the state then follows REQ-005.
REQ-017 Fetch-to-offer latency SHALL be one cycle: mem_ack at edge N gives ir_load=1 after edge N.
REQ-018 Best-case throughput SHALL be one instruction per 2 cycles (one FETCH cycle, one DELIVER cycle).
REQ-019 ir_data SHALL change only on a REQ-006 capture.

Reset
REQ-020 When rst=0 the block SHALL immediately (asynchronously) force state=IDLE, pc=0, ir_data=0, mem_rd=0, ir_load=0 and busy=0.
REQ-021 Reset asserted mid-fetch or mid-deliver SHALL abandon the operation with no transfer.
REQ-022 After rst returns to 1, the first action SHALL be a REQ-005 evaluation on the next edge.

Verification
REQ-023 Reset then run=1, memory acks every request with no wait (mem_data = address+0x100), ir_ready=1 -> ir_data sequence 0x100, 0x101, 0x102 with ir_load asserted on alternate cycles and pc = 0, 1, 2.
REQ-024 Memory acks with 3 wait cycles and ir_ready held low for 4 DELIVER cycles -> mem_rd high 4 cycles per fetch; ir_load and ir_data stable throughout the stall; pc increments only on acceptance.
REQ-025 Branch to 0x40 in FETCH coincident with mem_ack -> word discarded, one FLUSH cycle with mem_rd=0, next fetch at mem_addr=0x40.
REQ-026 Branch to 0x10 in DELIVER: with ir_ready=1 -> instruction accepted and next mem_addr=0x10; with ir_ready=0 -> ir_load drops and next mem_addr=0x10 with no transfer.
REQ-027 pc=0xFF accepted -> next mem_addr=0x00; run=0 at acceptance -> IDLE, busy=0, no further mem_rd.
REQ-028 rst pulsed low while in DELIVER -> ir_load, mem_rd, pc and ir_data are 0 immediately without waiting for a clock edge.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: requests words from program memory, offers them to the
// instruction register, and redirects the program counter on branch requests.
module instr_fetch_unit #(
    parameter int word_size    = 10,
    parameter int address_size = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    output logic [address_size-1:0] mem_addr,
    output logic                    mem_rd,
    input  logic                    mem_ack,
    input  logic [word_size-1:0]    mem_data,
    output logic [word_size-1:0]    ir_data,
    output logic                    ir_load,
    input  logic                    ir_ready,
    input  logic                    branch_taken,
    input  logic [address_size-1:0] branch_addr,
    output logic [address_size-1:0] pc,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        FLUSH   = 2'd2,
        DELIVER = 2'd3
    } state_t;

    localparam logic [address_size-1:0] PC_ONE = {{(address_size-1){1'b0}}, 1'b1};

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [address_size-1:0] r_pc;
    logic [address_size-1:0] w_pc_nxt;
    logic [word_size-1:0]    r_ir_data;
    logic                    w_capture;
    logic                    r_mem_rd;
    logic                    r_ir_load;
    logic                    r_busy;

    // Next-state, next-pc and capture decision for the current cycle
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (branch_taken) begin
                    w_pc_nxt = branch_addr;
                end else begin
                    w_pc_nxt = r_pc;
                end
                if (run) begin
                    w_state_nxt = FETCH;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            FETCH: begin
                // A branch wins over a coincident ack: the fetched word is stale.
                if (branch_taken) begin
                    w_pc_nxt    = branch_addr;
                    w_state_nxt = FLUSH;
                end else if (mem_ack) begin
                    w_capture   = 1'b1;
                    w_state_nxt = DELIVER;
                end else begin
                    w_state_nxt = FETCH;
                end
            end
            FLUSH: begin
                if (branch_taken) begin
                    w_pc_nxt = branch_addr;
                end else begin
                    w_pc_nxt = r_pc;
                end
                w_state_nxt = FETCH;
            end
            DELIVER: begin
                if (ir_ready) begin
                    if (branch_taken) begin
                        w_pc_nxt = branch_addr;
                    end else begin
                        w_pc_nxt = r_pc + PC_ONE;
                    end
                    if (run) begin
                        w_state_nxt = FETCH;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (branch_taken) begin
                    // Pending instruction is dropped; refetch from the target.
                    w_pc_nxt    = branch_addr;
                    w_state_nxt = FETCH;
                end else begin
                    w_state_nxt = DELIVER;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_pc_nxt    = r_pc;
            end
        endcase
    end

    // State, pc and instruction registers; outputs registered from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_pc      <= {address_size{1'b0}};
            r_ir_data <= {word_size{1'b0}};
            r_mem_rd  <= 1'b0;
            r_ir_load <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_capture) begin
                r_ir_data <= mem_data;
            end else begin
                r_ir_data <= r_ir_data;
            end
            r_mem_rd  <= (w_state_nxt == FETCH);
            r_ir_load <= (w_state_nxt == DELIVER);
            r_busy    <= (w_state_nxt != IDLE);
        end
    end

    assign mem_addr = r_pc;
    assign pc       = r_pc;
    assign mem_rd   = r_mem_rd;
    assign ir_data  = r_ir_data;
    assign ir_load  = r_ir_load;
    assign busy     = r_busy;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a directed vector table plus
// hand-written wait-state and asynchronous-reset sequences.
module tb_instr_fetch_unit;

    logic       clk;
    logic       rst;
    logic       run;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic       mem_ack;
    logic [9:0] mem_data;
    logic [9:0] ir_data;
    logic       ir_load;
    logic       ir_ready;
    logic       branch_taken;
    logic [7:0] branch_addr;
    logic [7:0] pc;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       run;
        logic       ack;
        logic [9:0] data;
        logic       rdy;
        logic       br;
        logic [7:0] baddr;
        logic [7:0] e_pc;
        logic       e_rd;
        logic       e_ld;
        logic       e_busy;
        logic [9:0] e_ir;
    } vec_t;

    localparam int NVEC = 27;
    vec_t vecs [NVEC];

    instr_fetch_unit #(.word_size(10), .address_size(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_ack      (mem_ack),
        .mem_data     (mem_data),
        .ir_data      (ir_data),
        .ir_load      (ir_load),
        .ir_ready     (ir_ready),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .pc           (pc),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic r, input logic a, input logic [9:0] d,
                                input logic rd, input logic b, input logic [7:0] ba,
                                input logic [7:0] epc, input logic erd, input logic eld,
                                input logic ebusy, input logic [9:0] eir);
        vec_t v;
        v.run = r;   v.ack = a;    v.data = d;    v.rdy = rd;    v.br = b;
        v.baddr = ba; v.e_pc = epc; v.e_rd = erd; v.e_ld = eld;  v.e_busy = ebusy;
        v.e_ir = eir;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] epc, input logic erd,
                             input logic eld, input logic ebusy, input logic [9:0] eir);
        check({tag, ".pc"},       {24'd0, pc},       {24'd0, epc});
        check({tag, ".mem_addr"}, {24'd0, mem_addr}, {24'd0, epc});
        check({tag, ".mem_rd"},   {31'd0, mem_rd},   {31'd0, erd});
        check({tag, ".ir_load"},  {31'd0, ir_load},  {31'd0, eld});
        check({tag, ".busy"},     {31'd0, busy},     {31'd0, ebusy});
        check({tag, ".ir_data"},  {22'd0, ir_data},  {22'd0, eir});
    endtask

    task automatic drive(input logic r, input logic a, input logic [9:0] d,
                         input logic rd, input logic b, input logic [7:0] ba);
        run = r; mem_ack = a; mem_data = d; ir_ready = rd; branch_taken = b; branch_addr = ba;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rd_cycles;

        // run, ack, data, rdy, br, baddr  ->  pc, mem_rd, ir_load, busy, ir_data
        vecs[0]  = mk(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00,  8'h00, 1'b0, 1'b0, 1'b0, 10'h000);
        vecs[1]  = mk(1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 8'h05,  8'h05, 1'b0, 1'b0, 1'b0, 10'h000);
        vecs[2]  = mk(1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 8'h00,  8'h00, 1'b0, 1'b0, 1'b0, 10'h000);
        vecs[3]  = mk(1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00,  8'h00, 1'b1, 1'b0, 1'b1, 10'h000);
        vecs[4]  = mk(1'b1, 1'b1, 10'h100, 1'b0, 1'b0, 8'h00,  8'h00, 1'b0, 1'b1, 1'b1, 10'h100);
        vecs[5]  = mk(1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 8'h00,  8'h01, 1'b1, 1'b0, 1'b1, 10'h100);
        vecs[6]  = mk(1'b1, 1'b1, 10'h101, 1'b0, 1'b0, 8'h00,  8'h01, 1'b0, 1'b1, 1'b1, 10'h101);
        vecs[7]  = mk(1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 8'h00,  8'h02, 1'b1, 1'b0, 1'b1, 10'h101);
        vecs[8]  = mk(1'b1, 1'b1, 10'h102, 1'b0, 1'b0, 8'h00,  8'h02, 1'b0, 1'b1, 1'b1, 10'h102);
        vecs[9]  = mk(1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00,  8'h02, 1'b0, 1'b1, 1'b1, 10'h102);
        vecs[10] = mk(1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 8'h00,  8'h03, 1'b1, 1'b0, 1'b1, 10'h102);
        vecs[11] = mk(1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00,  8'h03, 1'b1, 1'b0, 1'b1, 10'h102);
        vecs[12] = mk(1'b1, 1'b1, 10'h3FF, 1'b0, 1'b1, 8'h40,  8'h40, 1'b0, 1'b0, 1'b1, 10'h102);
        vecs[13] = mk(1'b1, 1'b1, 10'h155, 1'b0, 1'b0, 8'h00,  8'h40, 1'b1, 1'b0, 1'b1, 10'h102);
        vecs[14] = mk(1'b1, 1'b1, 10'h140, 1'b0, 1'b0, 8'h00,  8'h40, 1'b0, 1'b1, 1'b1, 10'h140);
        vecs[15] = mk(1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 8'h10,  8'h10, 1'b1, 1'b0, 1'b1, 10'h140);
        vecs[16] = mk(1'b1, 1'b1, 10'h110, 1'b0, 1'b0, 8'h00,  8'h10, 1'b0, 1'b1, 1'b1, 10'h110);
        vecs[17] = mk(1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 8'h00,  8'h11, 1'b1, 1'b0, 1'b1, 10'h110);
        vecs[18] = mk(1'b1, 1'b1, 10'h111, 1'b0, 1'b0, 8'h00,  8'h11, 1'b0, 1'b1, 1'b1, 10'h111);
        vecs[19] = mk(1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 8'h10,  8'h10, 1'b1, 1'b0, 1'b1, 10'h111);
        vecs[20] = mk(1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 8'h77,  8'h77, 1'b0, 1'b0, 1'b1, 10'h111);
        vecs[21] = mk(1'b1, 1'b1, 10'h2AA, 1'b0, 1'b1, 8'hFF,  8'hFF, 1'b1, 1'b0, 1'b1, 10'h111);
        vecs[22] = mk(1'b1, 1'b1, 10'h1FF, 1'b0, 1'b0, 8'h00,  8'hFF, 1'b0, 1'b1, 1'b1, 10'h1FF);
        vecs[23] = mk(1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 8'h00,  8'h00, 1'b1, 1'b0, 1'b1, 10'h1FF);
        vecs[24] = mk(1'b1, 1'b1, 10'h100, 1'b0, 1'b0, 8'h00,  8'h00, 1'b0, 1'b1, 1'b1, 10'h100);
        vecs[25] = mk(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 8'h00,  8'h01, 1'b0, 1'b0, 1'b0, 10'h100);
        vecs[26] = mk(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00,  8'h01, 1'b0, 1'b0, 1'b0, 10'h100);

        // Asynchronous reset at start, checked before any clock edge
        rst = 1'b1;
        drive(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00);
        #2 rst = 1'b0;
        #1 check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 10'h000);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].run, vecs[i].ack, vecs[i].data, vecs[i].rdy, vecs[i].br, vecs[i].baddr);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_rd, vecs[i].e_ld,
                      vecs[i].e_busy, vecs[i].e_ir);
        end

        // Three wait cycles on memory, then a four-cycle consumer stall
        rd_cycles = 0;
        drive(1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00);
        step();
        if (mem_rd) rd_cycles++;
        check_all("wait.enter", 8'h01, 1'b1, 1'b0, 1'b1, 10'h100);
        for (int w = 0; w < 3; w++) begin
            step();
            if (mem_rd) rd_cycles++;
            check_all($sformatf("wait%0d", w), 8'h01, 1'b1, 1'b0, 1'b1, 10'h100);
        end
        drive(1'b1, 1'b1, 10'h101, 1'b0, 1'b0, 8'h00);
        step();
        if (mem_rd) rd_cycles++;
        check("wait.rd_cycles", rd_cycles, 32'd4);
        check_all("stall.enter", 8'h01, 1'b0, 1'b1, 1'b1, 10'h101);
        drive(1'b1, 1'b1, 10'h3C3, 1'b0, 1'b0, 8'h00);
        for (int s = 0; s < 3; s++) begin
            step();
            check_all($sformatf("stall%0d", s), 8'h01, 1'b0, 1'b1, 1'b1, 10'h101);
        end
        drive(1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 8'h00);
        step();
        check_all("stall.accept", 8'h02, 1'b1, 1'b0, 1'b1, 10'h101);

        // Reset pulsed while DELIVER is pending: outputs clear without an edge
        drive(1'b1, 1'b1, 10'h102, 1'b0, 1'b0, 8'h00);
        step();
        check_all("rstdel.pre", 8'h02, 1'b0, 1'b1, 1'b1, 10'h102);
        drive(1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 8'h00);
        #2 rst = 1'b0;
        #1 check_all("rstdel.async", 8'h00, 1'b0, 1'b0, 1'b0, 10'h000);
        step();
        check_all("rstdel.held", 8'h00, 1'b0, 1'b0, 1'b0, 10'h000);
        rst = 1'b1;
        drive(1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00);
        step();
        check_all("rstdel.release", 8'h00, 1'b1, 1'b0, 1'b1, 10'h000);

        // Reset mid-fetch abandons the request; run=0 afterwards keeps it idle
        #2 rst = 1'b0;
        #1 check_all("rstfetch.async", 8'h00, 1'b0, 1'b0, 1'b0, 10'h000);
        step();
        rst = 1'b1;
        drive(1'b0, 1'b1, 10'h155, 1'b1, 1'b0, 8'h00);
        step();
        check_all("rstfetch.idle", 8'h00, 1'b0, 1'b0, 1'b0, 10'h000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
